// File: rtl/partial_led_sequencer.sv
// AXI4-Lite write/read-back sequencer: writes a test vector to each
// register, reads it back, and reports pass or the first failure.
module partial_led_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          NUM_REGS       = 4,
  parameter logic [31:0] TEST_DATA0     = 32'h0101FFFF,
  parameter logic [31:0] TEST_DATA1     = 32'habcd0001,
  parameter logic [31:0] TEST_DATA2     = 32'hdead0011,
  parameter logic [31:0] TEST_DATA3     = 32'hbeef0011,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_resp,
  output logic        err_data,
  output logic        err_timeout,
  output logic [1:0]  fail_index,
  output logic [31:0] rd_last,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAST = 2'(NUM_REGS - 1);
  localparam logic [3:0][31:0] TDATA =
    {TEST_DATA3, TEST_DATA2, TEST_DATA1, TEST_DATA0};

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RADDR, RDATA, FIN
  } state_t;

  state_t state, state_next;

  logic [1:0]    index;
  logic [31:0]   addr;
  logic [CW-1:0] wait_cnt;
  logic          aw_done;
  logic          w_done;
  logic          tmo;
  logic [31:0]   exp_data;

  assign exp_data     = TDATA[index];
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_WDATA  = exp_data;
  assign M_AXI_WSTRB  = 4'hF;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and handshake outputs, all decoded from the state flops.
  always_comb begin
    state_next    = state;
    tmo           = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    busy          = (state != IDLE);
    done          = (state == FIN);
    unique case (state)
      IDLE: begin
        if (start) state_next = WR;
      end
      WR: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if (aw_done && w_done) begin
          state_next = WRESP;
        end else if (wait_cnt == WAIT_MAX) begin
          tmo        = 1'b1;
          state_next = FIN;
        end
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          state_next = (M_AXI_BRESP != 2'b00) ? FIN : RADDR;
        end else if (wait_cnt == WAIT_MAX) begin
          tmo        = 1'b1;
          state_next = FIN;
        end
      end
      RADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_next = RDATA;
        end else if (wait_cnt == WAIT_MAX) begin
          tmo        = 1'b1;
          state_next = FIN;
        end
      end
      RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00 ||
              M_AXI_RDATA != exp_data ||
              index == LAST)
            state_next = FIN;
          else
            state_next = WR;
        end else if (wait_cnt == WAIT_MAX) begin
          tmo        = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-state wait counter and write-channel completion flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wait_cnt <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (state_next != state || state == IDLE || state == FIN)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + CW'(1);
      aw_done <= (state == WR) && (state_next == WR) &&
                 (aw_done || (M_AXI_AWVALID && M_AXI_AWREADY));
      w_done  <= (state == WR) && (state_next == WR) &&
                 (w_done || (M_AXI_WVALID && M_AXI_WREADY));
    end
  end

  // Register walk, result flags and read-back capture.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      index       <= '0;
      addr        <= '0;
      pass        <= 1'b0;
      err_resp    <= 1'b0;
      err_data    <= 1'b0;
      err_timeout <= 1'b0;
      fail_index  <= '0;
      rd_last     <= '0;
    end else begin
      if (tmo) begin
        err_timeout <= 1'b1;
        fail_index  <= index;
      end
      case (state)
        IDLE: begin
          if (start) begin
            index       <= '0;
            addr        <= BASE_ADDR;
            pass        <= 1'b0;
            err_resp    <= 1'b0;
            err_data    <= 1'b0;
            err_timeout <= 1'b0;
            fail_index  <= '0;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID && M_AXI_BRESP != 2'b00) begin
            err_resp   <= 1'b1;
            fail_index <= index;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID) begin
            rd_last <= M_AXI_RDATA;
            if (M_AXI_RRESP != 2'b00) begin
              err_resp   <= 1'b1;
              fail_index <= index;
            end else if (M_AXI_RDATA != exp_data) begin
              err_data   <= 1'b1;
              fail_index <= index;
            end else if (index == LAST) begin
              pass <= 1'b1;
            end else begin
              index <= index + 2'd1;
              addr  <= addr + 32'h4;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_partial_led_sequencer.sv
// Bench for partial_led_sequencer: table of slave behaviours plus
// hand sequences for reset state and reset in the middle of a write.
module tb_partial_led_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic        err_resp, err_data, err_timeout;
  logic [1:0]  fail_index;
  logic [31:0] rd_last;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  partial_led_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_resp(err_resp), .err_data(err_data),
    .err_timeout(err_timeout), .fail_index(fail_index),
    .rd_last(rd_last),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Slave behaviour knobs
  logic wdelay = 1'b0;
  logic bad_rd = 1'b0;
  logic bresp_err = 1'b0;
  logic ar_block = 1'b0;
  logic aw_block = 1'b0;

  logic [31:0] mem [4];
  logic [31:0] awaddr_l, wdata_l;
  logic        got_aw, got_w;
  logic [1:0]  w_cnt;
  logic        bvalid, rvalid;
  logic [1:0]  bresp;
  logic [31:0] rdata;

  assign M_AXI_AWREADY = !aw_block;
  assign M_AXI_WREADY  = wdelay ? (w_cnt == 2'd3) : 1'b1;
  assign M_AXI_ARREADY = !ar_block;
  assign M_AXI_BVALID  = bvalid;
  assign M_AXI_BRESP   = bresp;
  assign M_AXI_RVALID  = rvalid;
  assign M_AXI_RDATA   = rdata;
  assign M_AXI_RRESP   = 2'b00;

  // Storing AXI4-Lite slave with optional faults
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
      rvalid <= 1'b0;
      rdata  <= '0;
      w_cnt  <= 2'd0;
    end else begin
      if (got_aw && got_w && !bvalid) begin
        mem[awaddr_l[3:2]] <= wdata_l;
        bvalid <= 1'b1;
        bresp  <= (bresp_err && awaddr_l[3:2] == 2'd1) ? 2'b10 : 2'b00;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end
      if (bvalid && M_AXI_BREADY) bvalid <= 1'b0;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        awaddr_l <= M_AXI_AWADDR;
        got_aw   <= 1'b1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        wdata_l <= M_AXI_WDATA;
        got_w   <= 1'b1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) w_cnt <= 2'd0;
      else if (M_AXI_AWVALID && M_AXI_AWREADY) w_cnt <= 2'd1;
      else if (w_cnt != 2'd0 && w_cnt != 2'd3) w_cnt <= w_cnt + 2'd1;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        rvalid <= 1'b1;
        rdata  <= (bad_rd && M_AXI_ARADDR == 32'h8) ?
                  32'hdead0010 : mem[M_AXI_ARADDR[3:2]];
      end else if (rvalid && M_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Bus activity counters
  int n_b = 0, n_ar = 0, n_c = 0, n_arv = 0, n_wonly = 0;
  always @(posedge ACLK) begin
    if (M_AXI_BVALID && M_AXI_BREADY) n_b <= n_b + 1;
    if (M_AXI_ARVALID && M_AXI_ARREADY) n_ar <= n_ar + 1;
    if ((M_AXI_AWVALID && M_AXI_AWREADY && M_AXI_AWADDR == 32'hC) ||
        (M_AXI_ARVALID && M_AXI_ARREADY && M_AXI_ARADDR == 32'hC))
      n_c <= n_c + 1;
    if (M_AXI_ARVALID) n_arv <= n_arv + 1;
    if (!M_AXI_AWVALID && M_AXI_WVALID) n_wonly <= n_wonly + 1;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_seq(output int bcyc, output logic seen);
    bcyc = 0;
    seen = 1'b0;
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (busy) bcyc++;
      if (done) seen = 1'b1;
      else @(negedge ACLK);
    end
  endtask

  typedef struct {
    logic        wdelay, bad_rd, bresp_err, ar_block;
    logic        pass, e_resp, e_data, e_tmo;
    logic [1:0]  fidx;
    logic [31:0] rd_last;
    int          n_b, n_ar, n_c, n_arv, min_busy;
    logic        wonly;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   bcyc;
    logic seen;
    int   b0, ar0, c0, arv0, wo0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                2'd0, 32'hbeef0011, 4, 4, 2, 4, 21, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                2'd0, 32'hbeef0011, 4, 4, 2, 4, 33, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                2'd2, 32'hdead0010, 3, 3, 0, 3, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                2'd1, 32'h0101ffff, 2, 1, 0, 1, 0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                2'd0, 32'h0101ffff, 1, 0, 0, 1024, 0, 1'b0};

    // Reset state
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_flags",
          {26'd0, pass, err_resp, err_data, err_timeout, fail_index},
          32'd0);
    chk32("rst_rd_last", rd_last, 32'd0);
    chk32("rst_handshake",
          {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
           M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    chk1("idle_no_start_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      wdelay    = vecs[i].wdelay;
      bad_rd    = vecs[i].bad_rd;
      bresp_err = vecs[i].bresp_err;
      ar_block  = vecs[i].ar_block;
      b0 = n_b; ar0 = n_ar; c0 = n_c; arv0 = n_arv; wo0 = n_wonly;
      run_seq(bcyc, seen);
      chk1($sformatf("v%0d_done", i), seen, 1'b1);
      chk1($sformatf("v%0d_pass", i), pass, vecs[i].pass);
      chk1($sformatf("v%0d_err_resp", i), err_resp, vecs[i].e_resp);
      chk1($sformatf("v%0d_err_data", i), err_data, vecs[i].e_data);
      chk1($sformatf("v%0d_err_timeout", i), err_timeout, vecs[i].e_tmo);
      chk32($sformatf("v%0d_fail_index", i), 32'(fail_index),
            32'(vecs[i].fidx));
      chk32($sformatf("v%0d_rd_last", i), rd_last, vecs[i].rd_last);
      chk32($sformatf("v%0d_b_count", i), n_b - b0, vecs[i].n_b);
      chk32($sformatf("v%0d_ar_count", i), n_ar - ar0, vecs[i].n_ar);
      chk32($sformatf("v%0d_addr_c", i), n_c - c0, vecs[i].n_c);
      chk32($sformatf("v%0d_arvalid_cyc", i), n_arv - arv0,
            vecs[i].n_arv);
      chk1($sformatf("v%0d_w_only", i), (n_wonly - wo0) > 0,
           vecs[i].wonly);
      if (vecs[i].min_busy != 0)
        chk1($sformatf("v%0d_busy_min", i), bcyc >= vecs[i].min_busy,
             1'b1);
      @(negedge ACLK);
      chk1($sformatf("v%0d_done_pulse", i), done, 1'b0);
      chk1($sformatf("v%0d_idle_busy", i), busy, 1'b0);
      chk1($sformatf("v%0d_idle_arvalid", i), M_AXI_ARVALID, 1'b0);
      chk1($sformatf("v%0d_pass_hold", i), pass, vecs[i].pass);
    end

    // Reset while stalled in WR
    wdelay = 1'b0; bad_rd = 1'b0; bresp_err = 1'b0; ar_block = 1'b0;
    aw_block = 1'b1;
    @(negedge ACLK);
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    repeat (2) @(negedge ACLK);
    chk1("wr_awvalid_held", M_AXI_AWVALID, 1'b1);
    chk1("wr_busy", busy, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    chk1("arst_awvalid", M_AXI_AWVALID, 1'b0);
    chk1("arst_wvalid", M_AXI_WVALID, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk32("arst_rd_last", rd_last, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    aw_block = 1'b0;
    b0 = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      if (done || busy) b0++;
    end
    chk32("arst_no_resume", b0, 0);
    chk1("arst_no_pass", pass, 1'b0);
    run_seq(bcyc, seen);
    chk1("post_rst_done", seen, 1'b1);
    chk1("post_rst_pass", pass, 1'b1);
    chk32("post_rst_rd_last", rd_last, 32'hbeef0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/partial_led_sequencer.md
PARTIAL_LED_SEQUENCER -- requirements
Module: partial_led_sequencer

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, 32'h0000_0000: slave register 0 address.
- NUM_REGS, 4: registers exercised, 1..4.
- TEST_DATA0..3, 32'h0101FFFF / 32'habcd0001 / 32'hdead0011 / 32'hbeef0011: per-register write vectors.
- TIMEOUT_CYCLES, 1024: maximum wait for any single handshake.
REQ-002 Ports SHALL be (name direction width meaning):
- ACLK in 1: sole clock, all logic on rising edge.
- ARESETN in 1: reset, asynchronous assert, active-low.
- start in 1: one-cycle request to run a sequence.
- busy out 1: sequence in progress.
- done out 1: one-cycle completion pulse.
- pass out 1: last sequence passed.
- err_resp out 1: non-OKAY BRESP or RRESP seen.
- err_data out 1: read-back mismatch.
- err_timeout out 1: handshake exceeded TIMEOUT_CYCLES.
- fail_index out 2: register index of first failure.
- rd_last out 32: last captured RDATA.
- M_AXI_AWADDR out 32, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
- M_AXI_ARADDR out 32, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

Function
REQ-003 FSM states SHALL be IDLE, WR, WRESP, RADDR, RDATA, FIN.
REQ-004 IDLE with start=1 SHALL set index=0 and addr=BASE_ADDR, clear pass and all err_* flags and fail_index, and enter WR; start in any other state SHALL be ignored.
REQ-005 WR SHALL assert AWVALID and WVALID together in the first WR cycle, with AWADDR=addr, WDATA=TEST_DATA[index], WSTRB=4'hF, and AWPROT=ARPROT=3'b000.
REQ-006 Each of AWVALID and WVALID SHALL drop the cycle after its own READY handshake, independently; WR SHALL exit to WRESP only after both handshakes have completed, in either order or in the same cycle.
REQ-007 AWADDR/WDATA SHALL remain stable while the corresponding VALID is high.
REQ-008 WRESP SHALL hold BREADY=1. On BVALID: BRESP!=2'b00 SHALL set err_resp and fail_index=index and go to FIN; otherwise SHALL go to RADDR.
REQ-009 RADDR SHALL hold ARVALID=1 with ARADDR=addr until ARREADY, then go to RDATA.
REQ-010 RDATA SHALL hold RREADY=1. On RVALID: rd_last=RDATA. RRESP!=OKAY SHALL set err_resp. Otherwise RDATA!=TEST_DATA[index] SHALL set err_data. Either error SHALL set fail_index=index and go to FIN.
REQ-011 A matching read SHALL, if index==NUM_REGS-1, set pass=1 and go to FIN; otherwise increment index, add 32'h4 to addr, and return to WR.
REQ-012 Each write-read pair SHALL take at least 5 cycles with zero-wait slaves: WR, WRESP, RADDR, RDATA, plus 1 bubble.
REQ-013 A wait counter SHALL clear on each state entry and increment in WR/WRESP/RADDR/RDATA. Reaching TIMEOUT_CYCLES SHALL set err_timeout and fail_index=index, drop all VALID/READY outputs, and go to FIN.
REQ-014 FIN SHALL pulse done for exactly one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 pass, err_*, fail_index, and rd_last SHALL hold until the next accepted start.
REQ-017 addr arithmetic SHALL be 32-bit modulo.

Reset
REQ-018 ARESETN=0 SHALL immediately, with no clock, force state=IDLE and drive all M_AXI VALID/READY outputs, busy, done, pass, all err_*, fail_index, rd_last, index, and wait counter to 0.
REQ-019 Reset mid-transaction SHALL NOT complete, resume, or report the interrupted sequence.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Zero-wait OKAY slave that stores writes; start -> 4 writes and 4 reads at 0x0,0x4,0x8,0xC; done with pass=1; rd_last=32'hbeef0011.
- WREADY asserted 3 cycles after AWREADY -> AWVALID drops first, WVALID holds until WREADY, single B per write; pass=1.
- Slave returns 32'hdead0010 at 0x8 -> err_data=1, fail_index=2, pass=0, no access to 0xC.
- BRESP=2'b10 on register 1 -> err_resp=1, fail_index=1, no read issued for register 1.
- ARREADY held 0 -> err_timeout=1 after 1024 RADDR cycles, ARVALID dropped, done pulses.
- ARESETN=0 while in WR -> AWVALID=WVALID=busy=0 asynchronously; start after release runs a full sequence with pass=1.
